// File: rtl/tabajara_pkg.sv
// Shared definitions for the enemy shot unit.
//   shot_state_e : shot sequencer states (COOL/ARM/FLY/HIT)
//   Screen and player geometry in pixels, shot box height, 10-bit position helpers.
package tabajara_pkg;

    typedef enum logic [1:0] {
        ST_COOL = 2'd0,
        ST_ARM  = 2'd1,
        ST_FLY  = 2'd2,
        ST_HIT  = 2'd3
    } shot_state_e;

    localparam int unsigned POS_W      = 10;
    localparam int unsigned SCREEN_H   = 480;
    localparam int unsigned PLAYER_Y   = 440;
    localparam int unsigned PLAYER_W   = 32;
    localparam int unsigned PLAYER_H   = 16;
    localparam int unsigned SHOT_BOX_H = 4;

    localparam logic [POS_W-1:0] POS_MAX = '1;

    // 10-bit unsigned add that clips at 1023 instead of wrapping.
    function automatic logic [POS_W-1:0] sat_add(input logic [POS_W-1:0] a,
                                                 input logic [POS_W-1:0] b);
        logic [POS_W:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[POS_W] ? POS_MAX : sum[POS_W-1:0];
    endfunction

    // Clip a 12-bit intermediate position to the 10-bit screen range.
    function automatic logic [POS_W-1:0] clip12(input logic [11:0] v);
        return (v[11:10] != 2'b00) ? POS_MAX : v[POS_W-1:0];
    endfunction

endpackage

// File: rtl/enemy_shot_unit_tick_divider.sv
// tick_divider: emits a one-cycle tick every DIV enabled clock cycles.
//   clk    in  system clock
//   reset  in  asynchronous active-low reset (counter to 0)
//   clear  in  synchronous clear (counter to 0, no tick)
//   enable in  counter advances only while high
//   tick   out high on the DIV-th enabled cycle since the last wrap
module tick_divider #(
    parameter int unsigned DIV = 250000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic tick
);

    localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CNT_W'(1);
        end
    end

    assign tick = enable && !clear && (cnt_q == LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/enemy_shot_unit.sv
// enemy_shot_unit: spawns one enemy projectile under the selected shooter, moves it
// down the screen and detects a hit on the player.
//   clk, reset (async, active-low), restart (sync, active-high, same effect as reset)
//   estado_jogo      : 1 = running, anything else freezes every register
//   enemy_vivos      : live mask, bit i = linear enemy id i
//   ID_enemy_tiro_X/Y: selected shooter linear id / row
//   grid_x, grid_y   : enemy grid top-left; jogador_x : player left edge
//   score            : only used when SHOT_SPEEDUP_EN is defined
//   tiro_x, tiro_y, tiro_ativo : shot position / visibility; jogador_vivo : sticky 0 after hit
// Build option: define SHOT_SPEEDUP_EN to make the step grow with score (capped at 8 px).
//
// state | meaning
// COOL  | waiting COOLDOWN step ticks after reset or a retired shot
// ARM   | sampling the shooter each cycle until a live, in-range one appears
// FLY   | shot moving down; checks player overlap and bottom of screen
// HIT   | player was hit; absorbing until reset/restart
module enemy_shot_unit
    import tabajara_pkg::*;
#(
    parameter int unsigned LINHAS    = 4,
    parameter int unsigned COLUNAS   = 8,
    parameter int unsigned ENEMY_W   = 32,
    parameter int unsigned ENEMY_H   = 24,
    parameter int unsigned SHOT_STEP = 2,
    parameter int unsigned STEP_DIV  = 250000,
    parameter int unsigned COOLDOWN  = 50
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       restart,
    input  logic [1:0]                 estado_jogo,
    input  logic [LINHAS*COLUNAS-1:0]  enemy_vivos,
    input  logic [5:0]                 ID_enemy_tiro_X,
    input  logic [5:0]                 ID_enemy_tiro_Y,
    input  logic [9:0]                 grid_x,
    input  logic [9:0]                 grid_y,
    input  logic [9:0]                 jogador_x,
    input  logic [9:0]                 score,
    output logic [9:0]                 tiro_x,
    output logic [9:0]                 tiro_y,
    output logic                       tiro_ativo,
    output logic                       jogador_vivo
);

    localparam int unsigned NUM_ENEMY = LINHAS * COLUNAS;
    localparam int unsigned CD_W      = (COOLDOWN > 0) ? $clog2(COOLDOWN + 1) : 1;
    localparam logic [CD_W-1:0] CD_INIT = CD_W'(COOLDOWN);

    shot_state_e      state_q, state_d;
    logic [CD_W-1:0]  cooldown_q, cooldown_d;
    logic [9:0]       tiro_x_q, tiro_x_d;
    logic [9:0]       tiro_y_q, tiro_y_d;
    logic             tiro_ativo_q, tiro_ativo_d;
    logic             jogador_vivo_q, jogador_vivo_d;

    logic             running;
    logic             step_tick;
    logic [9:0]       step_px;

    assign running = (estado_jogo == 2'd1);

    tick_divider #(
        .DIV (STEP_DIV)
    ) u_step_div (
        .clk    (clk),
        .reset  (reset),
        .clear  (restart),
        .enable (running),
        .tick   (step_tick)
    );

`ifdef SHOT_SPEEDUP_EN
    logic [6:0] step_raw;
    assign step_raw = 7'(SHOT_STEP) + {1'b0, score[9:4]};
    assign step_px  = (step_raw > 7'd8) ? 10'd8 : {3'b000, step_raw};
`else
    logic unused_score;
    assign unused_score = ^score;
    assign step_px      = 10'(SHOT_STEP);
`endif

    // Shooter validation and spawn point. Column wraps modulo 64 if the row/id pair
    // is inconsistent; the 12-bit sums are then clipped to the screen range.
    logic [5:0]            shooter_col;
    logic [NUM_ENEMY-1:0]  vivos_shifted;
    logic                  shooter_ok;
    logic [11:0]           spawn_x_wide;
    logic [11:0]           spawn_y_wide;

    assign shooter_col   = ID_enemy_tiro_X - 6'(32'(ID_enemy_tiro_Y) * COLUNAS);
    assign vivos_shifted = enemy_vivos >> ID_enemy_tiro_X;
    assign shooter_ok    = (32'(ID_enemy_tiro_X) < NUM_ENEMY) && vivos_shifted[0];
    assign spawn_x_wide  = 12'(grid_x) + 12'(shooter_col) * 12'(ENEMY_W) + 12'(ENEMY_W / 2);
    assign spawn_y_wide  = 12'(grid_y) + (12'(ID_enemy_tiro_Y) + 12'd1) * 12'(ENEMY_H);

    logic [9:0] player_right;
    logic       player_hit;
    logic       off_screen;

    assign player_right = sat_add(jogador_x, 10'(PLAYER_W));
    assign player_hit   = (tiro_x_q >= jogador_x) && (tiro_x_q < player_right)
                       && (sat_add(tiro_y_q, 10'(SHOT_BOX_H)) >= 10'(PLAYER_Y))
                       && (tiro_y_q < 10'(PLAYER_Y + PLAYER_H));
    assign off_screen   = (tiro_y_q >= 10'(SCREEN_H));

    always_comb begin
        state_d        = state_q;
        cooldown_d     = cooldown_q;
        tiro_x_d       = tiro_x_q;
        tiro_y_d       = tiro_y_q;
        tiro_ativo_d   = tiro_ativo_q;
        jogador_vivo_d = jogador_vivo_q;

        if (restart) begin
            state_d        = ST_COOL;
            cooldown_d     = CD_INIT;
            tiro_x_d       = '0;
            tiro_y_d       = '0;
            tiro_ativo_d   = 1'b0;
            jogador_vivo_d = 1'b1;
        end else if (running) begin
            case (state_q)
                ST_COOL: begin
                    if (cooldown_q == '0) begin
                        state_d = ST_ARM;
                    end else if (step_tick) begin
                        cooldown_d = cooldown_q - CD_W'(1);
                    end
                end
                ST_ARM: begin
                    if (shooter_ok) begin
                        tiro_x_d     = clip12(spawn_x_wide);
                        tiro_y_d     = clip12(spawn_y_wide);
                        tiro_ativo_d = 1'b1;
                        state_d      = ST_FLY;
                    end
                end
                ST_FLY: begin
                    // Hit wins over retire when both are true in the same cycle.
                    if (player_hit) begin
                        tiro_ativo_d   = 1'b0;
                        jogador_vivo_d = 1'b0;
                        state_d        = ST_HIT;
                    end else if (off_screen) begin
                        tiro_ativo_d = 1'b0;
                        cooldown_d   = CD_INIT;
                        state_d      = ST_COOL;
                    end else if (step_tick) begin
                        tiro_y_d = sat_add(tiro_y_q, step_px);
                    end
                end
                ST_HIT: begin
                    tiro_ativo_d   = 1'b0;
                    jogador_vivo_d = 1'b0;
                end
                default: begin
                    state_d = ST_COOL;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= ST_COOL;
            cooldown_q     <= CD_INIT;
            tiro_x_q       <= '0;
            tiro_y_q       <= '0;
            tiro_ativo_q   <= 1'b0;
            jogador_vivo_q <= 1'b1;
        end else begin
            state_q        <= state_d;
            cooldown_q     <= cooldown_d;
            tiro_x_q       <= tiro_x_d;
            tiro_y_q       <= tiro_y_d;
            tiro_ativo_q   <= tiro_ativo_d;
            jogador_vivo_q <= jogador_vivo_d;
        end
    end

    assign tiro_x       = tiro_x_q;
    assign tiro_y       = tiro_y_q;
    assign tiro_ativo   = tiro_ativo_q;
    assign jogador_vivo = jogador_vivo_q;

endmodule
